div16x8_seq: RTL

DIV16X8_SEQ -- requirements
Module: div16x8_seq

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div16x8_seq_if.sv | 28 ++
 rtl/div_step.sv | 22 ++
 rtl/div16x8_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential 2W/W unsigned divider.
package div_seq_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice as wide.
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bits needed to count W-1 down to 0 (never narrower than one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div16x8_seq_if.sv
// Request/result bundle of the sequential divider.
interface div16x8_seq_if
    import div_seq_pkg::*;
#(
    parameter int W = DIV_W
);
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    // Requester side.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic         qbit_o
);
    logic [W+1:0] shifted;

    // Compare on the full shifted width so no carry is lost; the kept
    // remainder is always below the divisor, so W+1 bits hold it.
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {2'b00, divisor_i});
        rem_o   = qbit_o ? (shifted[W:0] - {1'b0, divisor_i}) : shifted[W:0];
    end
endmodule

// File: rtl/div16x8_seq.sv
// Radix-2 restoring unsigned divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per RUN cycle, with divide-by-zero and overflow detection.
module div16x8_seq
    import div_seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic          clk,
    input  logic          rst,
    div16x8_seq_if.slave  bus
);
    localparam int CNT_W = cnt_width(W);

    div_state_e     state_q;
    logic [W:0]     rem_q;        // partial remainder
    logic [2*W-1:0] dvd_q;        // dividend bits still to be shifted in, MSB first
    logic [W-1:0]   dsr_q;        // latched divisor
    logic [W-1:0]   quo_q;        // quotient under construction
    logic [CNT_W-1:0] cnt_q;      // remaining RUN steps minus one
    logic           special_q;    // result already decided at accept; just wait one cycle
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;
    logic           ovf_q;
    logic [W-1:0]   quot_res_q;
    logic [W-1:0]   rem_res_q;

    logic [W:0]     rem_d;
    logic           qbit_d;

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[2*W-1]),
        .divisor_i (dsr_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );

    // Control FSM plus datapath; all outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dsr_q     <= bus.divisor;
                        rem_q     <= {1'b0, bus.dividend[2*W-1:W]};
                        dvd_q     <= {bus.dividend[W-1:0], {W{1'b0}}};
                        quo_q     <= '0;
                        cnt_q     <= CNT_W'(W - 1);
                        dbz_q     <= 1'b0;
                        ovf_q     <= 1'b0;
                        special_q <= 1'b0;
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        if (bus.divisor == '0) begin
                            special_q  <= 1'b1;
                            dbz_q      <= 1'b1;
                            quot_res_q <= '1;
                            rem_res_q  <= bus.dividend[W-1:0];
                        end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                            // High half already >= divisor: quotient cannot fit W bits.
                            special_q  <= 1'b1;
                            ovf_q      <= 1'b1;
                            quot_res_q <= '1;
                            rem_res_q  <= '1;
                        end
                    end
                end
                RUN: begin
                    rem_q        <= rem_d;
                    dvd_q        <= {dvd_q[2*W-2:0], 1'b0};
                    quo_q[cnt_q] <= qbit_d;
                    cnt_q        <= cnt_q - CNT_W'(1);
                    if (special_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        // Bit 0 of quo_q is still clear here; the last step supplies it.
                        quot_res_q <= quo_q | W'(qbit_d);
                        rem_res_q  <= rem_d[W-1:0];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_res_q;
    assign bus.remainder   = rem_res_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
